// File: rtl/madd_scan_pkg.sv
// Shared types and constants for the approximate-madd error scanner.
package madd_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_e;

    typedef logic [5:0] vec_t;
    typedef logic [3:0] res_t;

    localparam int unsigned N_VEC = 64;

    function automatic res_t abs_diff(input res_t x, input res_t y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/madd_exact.sv
// Exact reference multiply-add: a*b+c on 2-bit operands packed in a 6-bit vector.
module madd_exact
    import madd_scan_pkg::*;
(
    input  vec_t vec_i,
    output res_t res_o
);

    logic [3:0] prod_s;

    // Largest result is 3*3+3 = 12, so the 4-bit sum never overflows.
    always_comb begin
        prod_s = {2'b00, vec_i[1:0]} * {2'b00, vec_i[3:2]};
        res_o  = prod_s + {2'b00, vec_i[5:4]};
    end

endmodule

// File: rtl/madd_err_scan.sv
// Exhaustive 64-vector error scan of an approximate 6-in/4-out madd.
// Optional sum_err accumulator is built only when MADD_ERR_SCAN_SUM_EN is defined.
module madd_err_scan
    import madd_scan_pkg::*;
#(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    input  logic [3:0] et_i,
    output logic [5:0] dut_in,
    input  logic [3:0] dut_out,
    output logic       busy,
    output logic       done,
    output logic [6:0] err_cnt,
    output logic [3:0] max_err,
    output logic       wce_ok,
    output logic [9:0] sum_err
);

    scan_state_e state_q, state_d;
    vec_t        vec_q, vec_d;
    vec_t        dut_in_q, dut_in_d;
    logic [2:0]  wait_q, wait_d;
    res_t        et_q, et_d;
    logic [6:0]  err_cnt_q, err_cnt_d;
    res_t        max_err_q, max_err_d;
    logic        wce_ok_q, wce_ok_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    res_t        exact_s;
    res_t        diff_s;
    logic        accept_s;
    logic        update_s;

    madd_exact u_exact (
        .vec_i (vec_q),
        .res_o (exact_s)
    );

    assign diff_s   = abs_diff(exact_s, dut_out);
    assign accept_s = (state_q == ST_IDLE) && start;
    // Abort wins over the sample update in the same cycle.
    assign update_s = (state_q == ST_SAMPLE) && !abort;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            wait_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; WAIT counts down SETTLE-1 cycles.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_DRIVE;
                else       state_d = ST_IDLE;
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (SETTLE > 1) begin
                    state_d = ST_WAIT;
                    wait_d  = 3'(SETTLE - 2);
                end else begin
                    state_d = ST_SAMPLE;
                end
            end
            ST_WAIT: begin
                if (abort)               state_d = ST_IDLE;
                else if (wait_q == 3'd0) state_d = ST_SAMPLE;
                else                     wait_d  = wait_q - 3'd1;
            end
            ST_SAMPLE: begin
                if (abort)               state_d = ST_IDLE;
                else if (vec_q == 6'd63) state_d = ST_DONE;
                else                     state_d = ST_DRIVE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and result next-values.
    always_comb begin
        vec_d     = vec_q;
        dut_in_d  = dut_in_q;
        et_d      = et_q;
        err_cnt_d = err_cnt_q;
        max_err_d = max_err_q;
        if (accept_s) begin
            et_d      = et_i;
            err_cnt_d = 7'd0;
            max_err_d = 4'd0;
            vec_d     = 6'd0;
        end else if (update_s) begin
            if (diff_s > et_q)      err_cnt_d = err_cnt_q + 7'd1;
            else                    err_cnt_d = err_cnt_q;
            if (diff_s > max_err_q) max_err_d = diff_s;
            else                    max_err_d = max_err_q;
            if (vec_q != 6'd63)     vec_d     = vec_q + 6'd1;
            else                    vec_d     = vec_q;
        end else if ((state_q == ST_DRIVE) && !abort) begin
            dut_in_d = vec_q;
        end else begin
            dut_in_d = dut_in_q;
        end
        busy_d   = (state_d == ST_DRIVE) || (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
        done_d   = (state_d == ST_DONE);
        wce_ok_d = (max_err_d <= et_d);
    end

    // Result and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q     <= 6'd0;
            dut_in_q  <= 6'd0;
            et_q      <= 4'd0;
            err_cnt_q <= 7'd0;
            max_err_q <= 4'd0;
            wce_ok_q  <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            dut_in_q  <= dut_in_d;
            et_q      <= et_d;
            err_cnt_q <= err_cnt_d;
            max_err_q <= max_err_d;
            wce_ok_q  <= wce_ok_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

`ifdef MADD_ERR_SCAN_SUM_EN
    logic [9:0] sum_q, sum_d;

    // Sum of absolute errors; 64*15 fits in 10 bits.
    always_comb begin
        if (accept_s)      sum_d = 10'd0;
        else if (update_s) sum_d = sum_q + {6'd0, diff_s};
        else               sum_d = sum_q;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sum_q <= 10'd0;
        else        sum_q <= sum_d;
    end

    assign sum_err = sum_q;
`else
    assign sum_err = 10'd0;
`endif

    assign dut_in  = dut_in_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err_cnt = err_cnt_q;
    assign max_err = max_err_q;
    assign wce_ok  = wce_ok_q;

endmodule

// File: tb/tb_madd_err_scan.sv
// Directed bench for madd_err_scan: one instance with SETTLE=1, one with SETTLE=3.
module tb_madd_err_scan;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [3:0] et_i = 4'd0;
    int         mode = 0;

    logic [5:0] dut_in1, dut_in3;
    logic [3:0] dut_out1, dut_out3;
    logic       busy1, busy3, done1, done3, wce1, wce3;
    logic [6:0] err1, err3;
    logic [3:0] max1, max3;
    logic [9:0] sum1, sum3;

    int nchk = 0;
    int nerr = 0;

`ifdef MADD_ERR_SCAN_SUM_EN
    localparam int SUM_ZERO_OUT = 240;
    localparam int SUM_FF_OUT   = 720;
`else
    localparam int SUM_ZERO_OUT = 0;
    localparam int SUM_FF_OUT   = 0;
`endif

    always #5 clk = ~clk;

    function automatic int exact_f(input logic [5:0] v);
        return int'(v[1:0]) * int'(v[3:2]) + int'(v[5:4]);
    endfunction

    function automatic logic [3:0] approx_f(input int m, input logic [5:0] v);
        if (m == 0)      return 4'(exact_f(v));
        else if (m == 1) return 4'd0;
        else             return 4'd15;
    endfunction

    assign dut_out1 = approx_f(mode, dut_in1);
    assign dut_out3 = approx_f(mode, dut_in3);

    madd_err_scan #(.SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .et_i(et_i),
        .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
        .err_cnt(err1), .max_err(max1), .wce_ok(wce1), .sum_err(sum1)
    );

    madd_err_scan #(.SETTLE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .et_i(et_i),
        .dut_in(dut_in3), .dut_out(dut_out3), .busy(busy3), .done(done3),
        .err_cnt(err3), .max_err(max3), .wce_ok(wce3), .sum_err(sum3)
    );

    task automatic check_eq(input string tag, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start and returns cycles from the start cycle until done is seen.
    task automatic run_scan(input bit sel3, input bit repulse, output int lat);
        lat = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat = 1;
        while (!(sel3 ? done3 : done1) && lat < 600) begin
            tick();
            lat++;
            if (repulse && lat == 40) start = 1'b1;
            else                      start = 1'b0;
        end
        start = 1'b0;
    endtask

    int lat;
    int exp_err, exp_max, exp_sum, d;
    int saw_done;

    initial begin
        // Reset values
        tick();
        check_eq("rst_dut_in", int'(dut_in1), 0);
        check_eq("rst_busy", int'(busy1), 0);
        check_eq("rst_done", int'(done1), 0);
        check_eq("rst_err_cnt", int'(err1), 0);
        check_eq("rst_max_err", int'(max1), 0);
        check_eq("rst_sum_err", int'(sum1), 0);
        check_eq("rst_wce_ok", int'(wce1), 1);
        rst_n = 1'b1;
        tick();

        // Correct model, et=0
        mode = 0; et_i = 4'd0;
        run_scan(1'b0, 1'b0, lat);
        check_eq("exact_latency", lat, 129);
        check_eq("exact_busy_in_done", int'(busy1), 0);
        check_eq("exact_err_cnt", int'(err1), 0);
        check_eq("exact_max_err", int'(max1), 0);
        check_eq("exact_sum_err", int'(sum1), 0);
        check_eq("exact_wce_ok", int'(wce1), 1);
        tick();
        check_eq("done_one_cycle", int'(done1), 0);
        check_eq("idle_after_done", int'(busy1), 0);
        repeat (3) tick();

        // Tied 0, et=3
        mode = 1; et_i = 4'd3;
        run_scan(1'b0, 1'b0, lat);
        check_eq("zero_latency", lat, 129);
        check_eq("zero_err_cnt", int'(err1), 27);
        check_eq("zero_max_err", int'(max1), 12);
        check_eq("zero_wce_ok", int'(wce1), 0);
        check_eq("zero_sum_err", int'(sum1), SUM_ZERO_OUT);
        et_i = 4'd9;
        repeat (5) tick();
        check_eq("idle_hold_err_cnt", int'(err1), 27);
        check_eq("idle_hold_wce_ok", int'(wce1), 0);

        // Tied 15, et=15
        mode = 2; et_i = 4'd15;
        run_scan(1'b0, 1'b0, lat);
        check_eq("ff_err_cnt", int'(err1), 0);
        check_eq("ff_max_err", int'(max1), 15);
        check_eq("ff_wce_ok", int'(wce1), 1);
        check_eq("ff_sum_err", int'(sum1), SUM_FF_OUT);
        repeat (3) tick();

        // Abort while dut_in=10 (SAMPLE of vector 10 is suppressed)
        mode = 1; et_i = 4'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        d = 0;
        while (dut_in1 != 6'd10 && d < 100) begin
            tick();
            d++;
        end
        check_eq("abort_reach_vec10", int'(dut_in1), 10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("abort_busy", int'(busy1), 0);
        exp_err = 0; exp_max = 0; exp_sum = 0;
        for (int v = 0; v < 10; v++) begin
            d = exact_f(6'(v));
            if (d > 0) exp_err++;
            if (d > exp_max) exp_max = d;
            exp_sum += d;
        end
`ifndef MADD_ERR_SCAN_SUM_EN
        exp_sum = 0;
`endif
        saw_done = 0;
        for (int i = 0; i < 140; i++) begin
            if (done1) saw_done = 1;
            tick();
        end
        check_eq("abort_no_done", saw_done, 0);
        check_eq("abort_err_cnt", int'(err1), exp_err);
        check_eq("abort_max_err", int'(max1), exp_max);
        check_eq("abort_sum_err", int'(sum1), exp_sum);
        repeat (130) tick();

        // Start re-pulsed mid-scan and in the DONE cycle
        mode = 1; et_i = 4'd3;
        run_scan(1'b0, 1'b1, lat);
        check_eq("repulse_latency", lat, 129);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq("done_start_ignored", int'(busy1), 0);
        check_eq("repulse_err_cnt", int'(err1), 27);
        check_eq("repulse_max_err", int'(max1), 12);

        // Reset mid-scan with SETTLE=3
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mode = 1; et_i = 4'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (60) tick();
        check_eq("s3_busy_mid", int'(busy3), 1);
        rst_n = 1'b0;
        #1;
        check_eq("s3_rst_busy", int'(busy3), 0);
        check_eq("s3_rst_done", int'(done3), 0);
        check_eq("s3_rst_dut_in", int'(dut_in3), 0);
        check_eq("s3_rst_err_cnt", int'(err3), 0);
        check_eq("s3_rst_max_err", int'(max3), 0);
        check_eq("s3_rst_sum_err", int'(sum3), 0);
        check_eq("s3_rst_wce_ok", int'(wce3), 1);
        tick();
        rst_n = 1'b1;
        tick();
        run_scan(1'b1, 1'b0, lat);
        check_eq("s3_latency", lat, 257);
        check_eq("s3_err_cnt", int'(err3), 27);
        check_eq("s3_max_err", int'(max3), 12);
        check_eq("s3_sum_err", int'(sum3), SUM_ZERO_OUT);
        tick();
        check_eq("s3_done_one_cycle", int'(done3), 0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/madd_err_scan.md
MADD_ERR_SCAN -- requirements
Module: madd_err_scan

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving the number of cycles from driving dut_in to sampling dut_out, legal range 1..7.
REQ-002 SHALL have port clk, input, 1: the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1: single-cycle scan request.
REQ-005 SHALL have port abort, input, 1: terminates a running scan.
REQ-006 SHALL have port et_i, input, 4: error threshold, captured at start.
REQ-007 SHALL have port dut_in, output, 6: registered operand vector driven to the approximate 6-in/4-out madd under test.
REQ-008 SHALL have port dut_out, input, 4: result returned by the approximate madd.
REQ-009 SHALL have port busy, output, 1: high while a scan is running.
REQ-010 SHALL have port done, output, 1: one-cycle pulse when a scan completes.
REQ-011 SHALL have port err_cnt, output, 7: number of vectors with error above threshold, range 0..64.
REQ-012 SHALL have port max_err, output, 4: worst-case absolute error.
REQ-013 SHALL have port wce_ok, output, 1: max_err <= captured threshold.
REQ-014 SHALL have port sum_err, output, 10: sum of absolute errors; see REQ-029.

Function
REQ-015 SHALL define the exact reference as a*b+c (4-bit), with a=vec[1:0], b=vec[3:2], c=vec[5:4].
REQ-016 SHALL implement FSM states IDLE, DRIVE, WAIT, SAMPLE, DONE.
REQ-017 SHALL, on start in IDLE: capture et_i, clear err_cnt/max_err/sum_err, set vec=0, go to DRIVE next cycle.
REQ-018 SHALL ignore start in any state other than IDLE, including DONE.
REQ-019 SHALL, in DRIVE, register vec onto dut_in and proceed to WAIT; WAIT lasts SETTLE-1 cycles (zero when SETTLE=1).
REQ-020 SHALL, in SAMPLE, compute diff=|exact(vec)-dut_out| and update state as follows:
- increment err_cnt if diff > et;
- max_err = max(max_err, diff);
- sum_err += diff.
REQ-021 SHALL, after SAMPLE, go to DRIVE with vec+1 if vec<63, else to DONE; vec SHALL NOT wrap within a scan.
REQ-022 SHALL give per-vector cost SETTLE+1 cycles; done SHALL assert exactly 64*(SETTLE+1)+1 cycles after the start cycle, for one cycle, then the FSM SHALL return to IDLE.
REQ-023 SHALL hold busy high in DRIVE, WAIT and SAMPLE, and low in IDLE and DONE.
REQ-024 SHALL, on abort in any busy state, go to IDLE next cycle without a done pulse; results keep their partial values; abort SHALL take priority over a same-cycle SAMPLE update.
REQ-025 SHALL treat et=0 as counting any mismatch, and et=15 as never counting.
REQ-026 SHALL keep results stable in IDLE until the next accepted start.

Reset
REQ-027 SHALL, with rst_n low, asynchronously force: state=IDLE, vec=0, dut_in=0, busy=0, done=0, err_cnt=0, max_err=0, sum_err=0, captured et=0, wce_ok=1.
REQ-028 SHALL, on reset mid-scan, abandon the scan with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-029 SHALL use macro MADD_ERR_SCAN_SUM_EN: when defined, the sum_err accumulator is built; when undefined, sum_err is tied to 0 and no accumulator register exists; all other behaviour is identical.

Structure
REQ-030 SHALL place the FSM state enum, the 6-bit vector type, the 4-bit result type and constant N_VEC=64 in shared package madd_scan_pkg.
REQ-031 SHALL implement the exact reference (REQ-015) as combinational sub-module madd_exact (6 in, 4 out), instantiated once.

Verification
REQ-032 SHALL cover: dut_out driven by a correct model, et_i=0, SETTLE=1 -> err_cnt=0, max_err=0, sum_err=0, wce_ok=1, done at cycle 129 after start.
REQ-033 SHALL cover: dut_out tied 0, et_i=3 -> err_cnt=27, max_err=12, wce_ok=0, sum_err=240 (0 without the macro).
REQ-034 SHALL cover: dut_out tied 15, et_i=15 -> err_cnt=0, max_err=15, wce_ok=1.
REQ-035 SHALL cover: abort asserted while dut_in=10 -> busy=0 next cycle, no done pulse, err_cnt holds its partial value.
REQ-036 SHALL cover: start re-pulsed mid-scan and in the DONE cycle -> ignored, so the scan length and results are unchanged.
REQ-037 SHALL cover: rst_n asserted mid-scan with SETTLE=3 -> all outputs reach reset values immediately; a following start completes in 257 cycles.
